// File: rtl/shift_left_seq.sv
// rtl/shift_left_seq.sv - iterative signed left shifter, one bit per clock, with overflow detect.
// Optional saturation on overflow is enabled by defining SHIFT_LEFT_SAT_EN.
module shift_left_seq #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   data;
  logic [CNT_W-1:0]   remaining;
  logic               ovf_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = (count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (remaining == CNT_W'(1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Overflow is judged on the pre-shift word: the bit about to become the MSB
  // must equal the current sign bit, otherwise the shift changes the sign.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data      <= '0;
      remaining <= '0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data      <= in;
            remaining <= count;
            ovf_r     <= 1'b0;
          end
        end
        SHIFT: begin
          ovf_r     <= ovf_r | (data[WIDTH-1] ^ data[WIDTH-2]);
          data      <= {data[WIDTH-2:0], 1'b0};
          remaining <= remaining - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign ovf = ovf_r;

`ifdef SHIFT_LEFT_SAT_EN
  logic sign_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sign_r <= in[WIDTH-1];
    end
  end

  always_comb begin
    out_q = data;
    if (ovf_r) begin
      out_q = sign_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign out_q = data;
`endif

endmodule
